// File: rtl/uart_ctrl_pkg.sv
// Shared constants and types for the UART bus controller: register map,
// CTRL bit positions and the transmit sequencer state encoding.
package uart_ctrl_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_TXDATA = 2'd1;
   localparam logic [1:0] ADDR_RXDATA = 2'd2;

   localparam int CTRL_SEND      = 0;
   localparam int CTRL_RX_NEW    = 1;
   localparam int CTRL_RX_EN     = 2;
   localparam int CTRL_FRAME_ERR = 3;
   localparam int CTRL_OVR_ERR   = 4;
   localparam int CTRL_TX_ERR    = 5;
   localparam int CTRL_RX_IE     = 6;
   localparam int CTRL_TX_BUSY   = 7;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } tx_state_e;

   // Sticky status bit: a set in the same cycle as a write-1-to-clear wins.
   function automatic logic sticky_next(input logic cur, input logic clr, input logic set);
      return (cur & ~clr) | set;
   endfunction

endpackage

// File: rtl/uart_tx_sequencer.sv
// Transmit handshake sequencer: raises transmitir until the core reports busy,
// waits for the frame to finish, and aborts if busy never rises.
module uart_tx_sequencer
   import uart_ctrl_pkg::*;
#(
   parameter int START_TIMEOUT = 2048
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic tx_busy,
   output logic transmitir,
   output logic done,
   output logic timeout
);

   localparam int CNT_W = $clog2(START_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(START_TIMEOUT);

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             transmitir_q, transmitir_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;

   // Next-state, start-timeout counter and registered handshake outputs.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      transmitir_d = transmitir_q;
      done_d       = 1'b0;
      timeout_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = LOAD;
               cnt_d        = {CNT_W{1'b0}};
               transmitir_d = 1'b1;
            end else begin
               transmitir_d = 1'b0;
            end
         end
         LOAD: begin
            state_d      = WAIT_BUSY;
            transmitir_d = 1'b1;
            cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_d      = WAIT_DONE;
               transmitir_d = 1'b0;
            end else if (cnt_q == CNT_MAX) begin
               state_d      = IDLE;
               transmitir_d = 1'b0;
               timeout_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = WAIT_DONE;
            end
         end
         default: begin
            state_d      = IDLE;
            transmitir_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= {CNT_W{1'b0}};
         transmitir_q <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         transmitir_q <= transmitir_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
      end
   end

   assign transmitir = transmitir_q;
   assign done       = done_q;
   assign timeout    = timeout_q;

endmodule

// File: rtl/uart_ctrl.sv
// Bus-facing register file for the UART core: CTRL/STATUS, TXDATA and RXDATA,
// receive capture with sticky flags, and the transmit sequencer instance.
module uart_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int START_TIMEOUT = 2048
)
(
   input  logic                  CLK100MHZ,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [1:0]            addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   output logic                  irq,
   output logic [DATA_WIDTH-1:0] dato_tx,
   output logic                  transmitir,
   input  logic                  tx_busy,
   output logic                  recibir,
   input  logic [DATA_WIDTH-1:0] dato_rx,
   input  logic                  rx_valid,
   input  logic                  rx_frame_error
);

   logic                  send_q, send_d;
   logic                  start_q, start_d;
   logic                  rx_new_q, rx_new_d;
   logic                  rx_en_q, rx_en_d;
   logic                  frame_err_q, frame_err_d;
   logic                  ovr_err_q, ovr_err_d;
   logic                  tx_err_q, tx_err_d;
   logic                  rx_ie_q, rx_ie_d;
   logic                  rx_valid_q, rx_valid_d;
   logic [DATA_WIDTH-1:0] txdata_q, txdata_d;
   logic [DATA_WIDTH-1:0] rxdata_q, rxdata_d;
   logic [DATA_WIDTH-1:0] dato_tx_q, dato_tx_d;
   logic [31:0]           rdata_q, rdata_d;

   logic        wr_ctrl, wr_txdata, rx_capture, clr_rx_new;
   logic [31:0] ctrl_word;
   logic        tx_done, tx_timeout;
   logic        unused_wdata;

   assign unused_wdata = ^wdata[31:DATA_WIDTH];

   uart_tx_sequencer #(
      .START_TIMEOUT (START_TIMEOUT)
   ) u_tx_sequencer (
      .clk        (CLK100MHZ),
      .rst_n      (rst_n),
      .start      (start_q),
      .tx_busy    (tx_busy),
      .transmitir (transmitir),
      .done       (tx_done),
      .timeout    (tx_timeout)
   );

   // Register writes, receive capture, sticky flags and read mux.
   always_comb begin
      wr_ctrl    = wr_en && (addr == ADDR_CTRL);
      wr_txdata  = wr_en && (addr == ADDR_TXDATA);
      rx_capture = rx_valid && !rx_valid_q && rx_en_q;
      clr_rx_new = wr_ctrl && wdata[CTRL_RX_NEW];

      // send doubles as the "sequencer busy" guard so repeat sends are dropped
      start_d = wr_ctrl && wdata[CTRL_SEND] && !send_q;
      if (start_d) begin
         send_d = 1'b1;
      end else if (tx_done || tx_timeout) begin
         send_d = 1'b0;
      end else begin
         send_d = send_q;
      end

      // a capture racing an acknowledge keeps rx_new and is not an overrun
      rx_new_d    = rx_capture | (rx_new_q & ~clr_rx_new);
      ovr_err_d   = sticky_next(ovr_err_q, wr_ctrl && wdata[CTRL_OVR_ERR],
                                rx_capture && rx_new_q && !clr_rx_new);
      frame_err_d = sticky_next(frame_err_q, wr_ctrl && wdata[CTRL_FRAME_ERR],
                                rx_capture && rx_frame_error);
      tx_err_d    = sticky_next(tx_err_q, wr_ctrl && wdata[CTRL_TX_ERR], tx_timeout);

      rx_en_d    = wr_ctrl ? wdata[CTRL_RX_EN] : rx_en_q;
      rx_ie_d    = wr_ctrl ? wdata[CTRL_RX_IE] : rx_ie_q;
      rx_valid_d = rx_valid;
      txdata_d   = wr_txdata ? wdata[DATA_WIDTH-1:0] : txdata_q;
      rxdata_d   = rx_capture ? dato_rx : rxdata_q;
      dato_tx_d  = start_q ? txdata_q : dato_tx_q;

      ctrl_word                 = 32'd0;
      ctrl_word[CTRL_SEND]      = send_q;
      ctrl_word[CTRL_RX_NEW]    = rx_new_q;
      ctrl_word[CTRL_RX_EN]     = rx_en_q;
      ctrl_word[CTRL_FRAME_ERR] = frame_err_q;
      ctrl_word[CTRL_OVR_ERR]   = ovr_err_q;
      ctrl_word[CTRL_TX_ERR]    = tx_err_q;
      ctrl_word[CTRL_RX_IE]     = rx_ie_q;
      ctrl_word[CTRL_TX_BUSY]   = tx_busy;

      rdata_d = rdata_q;
      if (rd_en) begin
         case (addr)
            ADDR_CTRL:   rdata_d = ctrl_word;
            ADDR_TXDATA: rdata_d = 32'(txdata_q);
            ADDR_RXDATA: rdata_d = 32'(rxdata_q);
            default:     rdata_d = 32'd0;
         endcase
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Register bank with synchronous active-low reset.
   always_ff @(posedge CLK100MHZ) begin
      if (!rst_n) begin
         send_q      <= 1'b0;
         start_q     <= 1'b0;
         rx_new_q    <= 1'b0;
         rx_en_q     <= 1'b0;
         frame_err_q <= 1'b0;
         ovr_err_q   <= 1'b0;
         tx_err_q    <= 1'b0;
         rx_ie_q     <= 1'b0;
         rx_valid_q  <= 1'b0;
         txdata_q    <= {DATA_WIDTH{1'b0}};
         rxdata_q    <= {DATA_WIDTH{1'b0}};
         dato_tx_q   <= {DATA_WIDTH{1'b0}};
         rdata_q     <= 32'd0;
      end else begin
         send_q      <= send_d;
         start_q     <= start_d;
         rx_new_q    <= rx_new_d;
         rx_en_q     <= rx_en_d;
         frame_err_q <= frame_err_d;
         ovr_err_q   <= ovr_err_d;
         tx_err_q    <= tx_err_d;
         rx_ie_q     <= rx_ie_d;
         rx_valid_q  <= rx_valid_d;
         txdata_q    <= txdata_d;
         rxdata_q    <= rxdata_d;
         dato_tx_q   <= dato_tx_d;
         rdata_q     <= rdata_d;
      end
   end

   assign rdata   = rdata_q;
   assign dato_tx = dato_tx_q;
   assign recibir = rx_en_q;
   assign irq     = rx_new_q & rx_ie_q;

endmodule
